// File: rtl/trigger_frame_pkg.sv
// Shared types and constants for the trigger frame capture block.
// Trailer word count follows TRIGGER_FRAME_TRAILER_EN.
package trigger_frame_pkg;

  typedef enum logic [1:0] {IDLE, POST, HDR, DATA} state_t;

  localparam int HDR_WORDS = 4;
  localparam int SAMPLE_W  = 16;
  localparam int TS_W      = 64;

`ifdef TRIGGER_FRAME_TRAILER_EN
  localparam int TRAILER_WORDS = 1;
`else
  localparam int TRAILER_WORDS = 0;
`endif

endpackage

// File: rtl/frame_ring_buffer.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module frame_ring_buffer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/trigger_frame_capture.sv
// Captures a pre/post-trigger sample frame into a ring buffer and streams it
// out as a 4-word timestamp header plus samples. Optional trailer: TRIGGER_FRAME_TRAILER_EN.
module trigger_frame_capture
  import trigger_frame_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int FRAME_LEN   = 256,
  parameter int PRE_SAMPLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic                       trigger,
  input  logic [TS_W-1:0]            timestamp,
  output logic [SAMPLE_W-1:0]        m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic                       busy,
  output logic                       overrun,
  output logic [15:0]                trig_dropped
);

  localparam int CNT_W = ADDR_W + 2;
  localparam logic [CNT_W-1:0]  HDR_C      = CNT_W'(HDR_WORDS);
  localparam logic [CNT_W-1:0]  SAMP_END_C = CNT_W'(HDR_WORDS + FRAME_LEN);
  localparam logic [CNT_W-1:0]  TOTAL_C    = CNT_W'(HDR_WORDS + FRAME_LEN + TRAILER_WORDS);
  localparam logic [ADDR_W-1:0] PRE_A      = ADDR_W'(PRE_SAMPLES);
  localparam logic [ADDR_W-1:0] POST_A     = ADDR_W'(FRAME_LEN - PRE_SAMPLES - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr, r_pre_cnt, r_post_cnt;
  logic                r_primed, r_overrun;
  logic [15:0]         r_drop;
  logic [TS_W-1:0]     r_ts;
  logic [CNT_W-1:0]    r_iss_cnt;
  logic [1:0]          r_out_cnt;
  logic                r_vld_p1, r_ram_p1, r_last_p1;
  logic [SAMPLE_W-1:0] r_word_p1;
  logic [1:0]          r_occ;
  logic [SAMPLE_W-1:0] r_q0_data, r_q1_data;
  logic                r_q0_last, r_q1_last;

  logic                w_accept, w_hdr_entry, w_pop, w_issue, w_issue_ram;
  logic [2:0]          w_used;
  logic [SAMPLE_W-1:0] w_src_word, w_rd_data, w_word_p1, w_trl;

  assign w_accept    = (r_state == IDLE) && enable && trigger && r_primed;
  assign w_hdr_entry = (r_state == POST) && enable && (r_post_cnt == '0);
  assign w_pop       = (r_occ != 2'd0) && m_ready;
  // Credits: skid entries plus the read in flight may never exceed two.
  assign w_used      = 3'(r_occ) + 3'(r_vld_p1) - 3'(w_pop);
  assign w_issue     = ((r_state == HDR) || (r_state == DATA)) &&
                       (r_iss_cnt < TOTAL_C) && (w_used < 3'd2);
  assign w_issue_ram = w_issue && (r_iss_cnt >= HDR_C) && (r_iss_cnt < SAMP_END_C);

`ifdef TRIGGER_FRAME_TRAILER_EN
  logic [SAMPLE_W-1:0] r_trl;
  always_ff @(posedge clk) begin
    if (w_hdr_entry) r_trl <= {r_overrun, r_drop[14:0]};
  end
  assign w_trl = r_trl;
`else
  assign w_trl = '0;
`endif

  frame_ring_buffer #(.ADDR_W(ADDR_W), .DATA_W(SAMPLE_W)) u_ram (
    .clk      (clk),
    .i_wr_en  (enable),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data($unsigned(x)),
    .i_rd_en  (w_issue_ram),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_pre_cnt <= '0;
      r_primed  <= 1'b0;
    end else if (enable) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (!r_primed) begin
        r_pre_cnt <= r_pre_cnt + 1'b1;
        if (r_pre_cnt == PRE_A - 1'b1) r_primed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_ts <= timestamp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_iss_cnt  <= '0;
      r_out_cnt  <= '0;
      r_overrun  <= 1'b0;
      r_drop     <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
      if (w_issue)     r_iss_cnt <= r_iss_cnt + 1'b1;
      if (w_issue_ram) r_rd_ptr  <= r_rd_ptr + 1'b1;
      if (enable && trigger && (r_state != IDLE) && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 1'b1;
      if (((r_state == HDR) || (r_state == DATA)) && enable &&
          (r_wr_ptr == r_rd_ptr) && (r_iss_cnt < SAMP_END_C))
        r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state    <= POST;
          r_rd_ptr   <= r_wr_ptr - PRE_A;
          r_post_cnt <= POST_A;
        end
        POST: if (enable) begin
          if (r_post_cnt == '0) begin
            r_state   <= HDR;
            r_iss_cnt <= '0;
            r_out_cnt <= '0;
          end else begin
            r_post_cnt <= r_post_cnt - 1'b1;
          end
        end
        HDR: if (w_pop) begin
          r_out_cnt <= r_out_cnt + 1'b1;
          if (r_out_cnt == 2'd3) r_state <= DATA;
        end
        DATA: if (w_pop && r_q0_last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_src_word = w_trl;
    if (r_iss_cnt < HDR_C) begin
      case (r_iss_cnt[1:0])
        2'd0:    w_src_word = r_ts[63:48];
        2'd1:    w_src_word = r_ts[47:32];
        2'd2:    w_src_word = r_ts[31:16];
        default: w_src_word = r_ts[15:0];
      endcase
    end
  end

  // Stage p0 -> p1: word select and RAM read issue.
  always_ff @(posedge clk) begin
    r_word_p1 <= w_src_word;
    r_ram_p1  <= w_issue_ram;
    r_last_p1 <= (r_iss_cnt == TOTAL_C - 1'b1);
  end

  assign w_word_p1 = r_ram_p1 ? w_rd_data : r_word_p1;

  // Stage p1 -> output: 2-entry skid buffer, head entry drives the stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ     <= '0;
      r_q0_data <= '0;
      r_q0_last <= 1'b0;
    end else begin
      r_occ <= r_occ + 2'(r_vld_p1) - 2'(w_pop);
      if (w_pop) begin
        if (r_vld_p1 && (r_occ == 2'd1)) begin
          r_q0_data <= w_word_p1;
          r_q0_last <= r_last_p1;
        end else begin
          r_q0_data <= r_q1_data;
          r_q0_last <= r_q1_last;
        end
      end else if (r_vld_p1 && (r_occ == 2'd0)) begin
        r_q0_data <= w_word_p1;
        r_q0_last <= r_last_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_vld_p1 && ((!w_pop && r_occ == 2'd1) || (w_pop && r_occ == 2'd2))) begin
      r_q1_data <= w_word_p1;
      r_q1_last <= r_last_p1;
    end
  end

  assign m_data       = r_q0_data;
  assign m_last       = r_q0_last;
  assign m_valid      = (r_occ != 2'd0);
  assign busy         = (r_state != IDLE);
  assign overrun      = r_overrun;
  assign trig_dropped = r_drop;

endmodule

// File: tb/tb_trigger_frame_capture.sv
// Directed bench for trigger_frame_capture: ramp input, frame capture, stream
// stalls, dropped triggers, overrun and mid-frame reset.
module tb_trigger_frame_capture;

  localparam int FLEN = 256;
  localparam int PRE  = 64;
`ifdef TRIGGER_FRAME_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif
  localparam int LEN = 4 + FLEN + TRL;
  localparam logic [63:0] TS_BASE = 64'hA5A5_0F0F_1234_0000;

  logic clk = 1'b0;
  logic reset, enable, trigger, m_ready, m_valid, m_last, busy, overrun;
  logic signed [15:0] x;
  logic [63:0] timestamp;
  logic [15:0] m_data, trig_dropped;

  always #5 clk = ~clk;

  trigger_frame_capture #(.ADDR_W(9), .FRAME_LEN(FLEN), .PRE_SAMPLES(PRE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .x(x), .trigger(trigger),
    .timestamp(timestamp), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .overrun(overrun), .trig_dropped(trig_dropped)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, xcnt = 0, en_mode = 0, rdy_mode = 0, trig_x = 0, stab_err = 0;
  logic [63:0] trig_ts;
  logic [16:0] q[$];
  bit          p_hold = 1'b0;
  logic [15:0] p_data;
  logic        p_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Record every handshake and verify the stream holds while stalled.
  always @(negedge clk) begin
    if (reset) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold && (!m_valid || m_data !== p_data || m_last !== p_last)) stab_err++;
      if (m_valid && m_ready) q.push_back({m_last, m_data});
      p_hold = m_valid && !m_ready;
      p_data = m_data;
      p_last = m_last;
    end
  end

  task automatic tick(input bit trig);
    bit en;
    en = (en_mode == 0) ? 1'b1 : (cyc % 2 == 0);
    if (trig) en = 1'b1;
    enable    = en;
    trigger   = trig;
    x         = 16'(xcnt);
    timestamp = TS_BASE + 64'(cyc);
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 2 == 1);
      default: m_ready = 1'b0;
    endcase
    if (trig) begin
      trig_x  = xcnt;
      trig_ts = timestamp;
    end
    @(posedge clk); #1;
    if (en) xcnt++;
    cyc++;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      tick(1'b0);
      k++;
    end
  endtask

  task automatic check_frame(input string nm, input logic [63:0] ets, input int fx,
                             input bit do_data, input logic [15:0] etrl);
    int errs = 0, lasts = 0;
    chk({nm, "_len"}, 64'(q.size()), 64'(LEN));
    if (q.size() == LEN) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_hdr%0d", nm, i), 64'(q[i][15:0]), 64'(ets[63-16*i -: 16]));
      for (int i = 0; i < FLEN; i++) if (q[4+i][15:0] !== 16'(fx + i)) errs++;
      for (int i = 0; i < LEN; i++) if (q[i][16]) lasts++;
      if (do_data) chk({nm, "_data_errs"}, 64'(errs), 64'd0);
      chk({nm, "_last_cnt"}, 64'(lasts), 64'd1);
      chk({nm, "_last_pos"}, 64'(q[LEN-1][16]), 64'd1);
`ifdef TRIGGER_FRAME_TRAILER_EN
      chk({nm, "_trailer"}, 64'(q[LEN-1][15:0]), 64'(etrl));
`else
      if (etrl == 16'hFFFF) chk({nm, "_trl_arg"}, 64'(etrl), 64'd0);
`endif
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fx;
    logic [63:0] ts;
    reset = 1'b1; enable = 1'b0; trigger = 1'b0; m_ready = 1'b1;
    x = '0; timestamp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_dropped", 64'(trig_dropped), 64'd0);
    reset = 1'b0;

    // Unprimed trigger at sample 10
    xcnt = 0;
    repeat (10) tick(1'b0);
    tick(1'b1);
    chk("unprimed_busy0", 64'(busy), 64'd0);
    repeat (5) tick(1'b0);
    chk("unprimed_busy1", 64'(busy), 64'd0);
    chk("unprimed_dropped", 64'(trig_dropped), 64'd0);
    chk("unprimed_words", 64'(q.size()), 64'd0);

    // Ramp, trigger at x=100 -> samples 36..291
    while (xcnt < 100) tick(1'b0);
    tick(1'b1);
    fx = trig_x - PRE; ts = trig_ts;
    chk("ramp_busy", 64'(busy), 64'd1);
    wait_words(LEN, 2000);
    repeat (4) tick(1'b0);
    check_frame("ramp", ts, fx, 1'b1, 16'h0000);
    chk("ramp_first_x", 64'(fx), 64'd36);
    chk("ramp_idle", 64'(busy), 64'd0);

    // Extra triggers during POST and during DATA
    q.delete();
    repeat (20) tick(1'b0);
    tick(1'b1);
    fx = trig_x - PRE; ts = trig_ts;
    repeat (5) tick(1'b0);
    tick(1'b1);
    wait_words(10, 2000);
    tick(1'b1);
    wait_words(LEN, 2000);
    repeat (20) tick(1'b0);
    check_frame("drop", ts, fx, 1'b1, 16'h0001);
    chk("drop_count", 64'(trig_dropped), 64'd2);

    // Toggling ready and enable
    q.delete();
    en_mode = 1; rdy_mode = 1;
    repeat (20) tick(1'b0);
    tick(1'b1);
    fx = trig_x - PRE; ts = trig_ts;
    wait_words(LEN, 5000);
    repeat (10) tick(1'b0);
    check_frame("toggle", ts, fx, 1'b1, 16'h0002);
    chk("toggle_stable", 64'(stab_err), 64'd0);

    // Long stall in DATA -> overrun
    q.delete();
    en_mode = 0; rdy_mode = 0;
    repeat (5) tick(1'b0);
    tick(1'b1);
    fx = trig_x - PRE; ts = trig_ts;
    wait_words(14, 2000);
    chk("ovr_before", 64'(overrun), 64'd0);
    rdy_mode = 2;
    repeat (300) tick(1'b0);
    chk("ovr_set", 64'(overrun), 64'd1);
    rdy_mode = 0;
    wait_words(LEN, 2000);
    repeat (5) tick(1'b0);
    check_frame("ovr", ts, fx, 1'b0, 16'h0002);
    chk("ovr_stable", 64'(stab_err), 64'd0);

    // Reset at DATA word 50, then a fresh frame
    q.delete();
    tick(1'b1);
    wait_words(54, 2000);
    chk("rst_mid_valid_before", 64'(m_valid), 64'd1);
    reset = 1'b1; enable = 1'b0; trigger = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_overrun", 64'(overrun), 64'd0);
    chk("rst_mid_dropped", 64'(trig_dropped), 64'd0);
    reset = 1'b0;
    q.delete();
    repeat (PRE) tick(1'b0);
    tick(1'b1);
    fx = trig_x - PRE; ts = trig_ts;
    chk("rst_new_busy", 64'(busy), 64'd1);
    wait_words(LEN, 2000);
    repeat (5) tick(1'b0);
    check_frame("rst_new", ts, fx, 1'b1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
